artec_frame_sync_tracker: RTL and testbench

- Multi-channel frame-number synchroniser for the DMA write path.
- Tracks end-of-frame completions per channel and per frame buffer.
- Emits a frame number once every enabled channel has completed that frame, using a valid/ready output with backpressure.
- Expires incomplete frames by timeout; sits between the per-channel AXIS monitors and the descriptor/commit logic.

---
 rtl/artec_dma_pkg.sv | 14 +
 rtl/artec_frame_sync_col.sv | 72 +++++++
 rtl/artec_frame_sync_tracker.sv | 148 ++++++++++++++
 tb/tb_artec_frame_sync_tracker.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/artec_dma_pkg.sv
// Shared types and constants for the DMA write-path frame tracking blocks.
package artec_dma_pkg;

  localparam int FB_NUM_DEF = 8;
  localparam int FNUM_W_DEF = $clog2(FB_NUM_DEF);

  typedef logic [FNUM_W_DEF-1:0] fnum_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sync_state_e;

endpackage

// File: rtl/artec_frame_sync_col.sv
// One frame-buffer column of the sync table: per-channel EOF bits, age
// counter, completion and expiry detection.
// Optional macro ARTEC_FRAME_SYNC_STAT_EN adds the missing-channel mask output.
module artec_frame_sync_col #(
  parameter int CH_NUM  = 5,
  parameter int FNUM_W  = 3,
  parameter int TO_W    = 16,
  parameter int COL_IDX = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [CH_NUM-1:0]        ch_enable_i,
  input  logic [CH_NUM-1:0]        eof_valid_i,
  input  logic [CH_NUM*FNUM_W-1:0] eof_fnum_i,
  input  logic [TO_W-1:0]          timeout_i,
  input  logic                     clear_i,
  output logic                     complete_o,
  output logic                     expire_o
`ifdef ARTEC_FRAME_SYNC_STAT_EN
  ,
  output logic [CH_NUM-1:0]        missing_o
`endif
);

  localparam logic [FNUM_W-1:0] IDX = FNUM_W'(COL_IDX);

  logic [CH_NUM-1:0] bits;
  logic [CH_NUM-1:0] set_hit;
  logic [TO_W-1:0]   age;
  logic              any_en;
  logic              any_set;
  logic              at_limit;

  // Decode which channels deliver an EOF for this column this cycle.
  always_comb begin
    set_hit = '0;
    for (int ch = 0; ch < CH_NUM; ch++) begin
      set_hit[ch] = eof_valid_i[ch] && (eof_fnum_i[ch*FNUM_W +: FNUM_W] == IDX);
    end
  end

  assign any_en     = |ch_enable_i;
  assign any_set    = |(bits & ch_enable_i);
  // Disabled channels count as done; with nothing enabled nothing completes.
  assign complete_o = any_en && (&(bits | ~ch_enable_i));
  assign at_limit   = (timeout_i != '0) && (age == timeout_i);
  // A column that is complete is emitted rather than dropped.
  assign expire_o   = at_limit && any_set && !complete_o;

`ifdef ARTEC_FRAME_SYNC_STAT_EN
  assign missing_o = ch_enable_i & ~bits;
`endif

  // Column bits: clear (emit/drop) beats a same-cycle set; disabled rows held at 0.
  always_ff @(posedge clk) begin
    if (!rstn || clear_i) begin
      bits <= '0;
    end else begin
      bits <= (bits | set_hit) & ch_enable_i;
    end
  end

  // Age counter: zero while empty, counts while pending, holds at the limit or all-ones.
  always_ff @(posedge clk) begin
    if (!rstn || clear_i || !any_set) begin
      age <= '0;
    end else if (!complete_o && !at_limit && (age != '1)) begin
      age <= age + TO_W'(1);
    end
  end

endmodule

// File: rtl/artec_frame_sync_tracker.sv
// Multi-channel frame-number synchroniser: collects per-channel EOFs per
// frame buffer, emits a frame once all enabled channels finish it, and
// expires stale partial frames.
// Optional macro ARTEC_FRAME_SYNC_STAT_EN adds drop/sync counters and drop mask.
//
// state | meaning
// IDLE  | no frame offered, sync_valid_o low
// HOLD  | frame sync_fnum_o offered, waiting for sync_ready_i
module artec_frame_sync_tracker
  import artec_dma_pkg::*;
#(
  parameter  int CH_NUM = 5,
  parameter  int FB_NUM = FB_NUM_DEF,
  parameter  int TO_W   = 16,
  localparam int FNUM_W = $clog2(FB_NUM)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [CH_NUM-1:0]        ch_enable_i,
  input  logic [TO_W-1:0]          timeout_i,
  input  logic [CH_NUM-1:0]        eof_valid_i,
  input  logic [CH_NUM*FNUM_W-1:0] eof_fnum_i,
  output logic                     sync_valid_o,
  input  logic                     sync_ready_i,
  output logic [FNUM_W-1:0]        sync_fnum_o,
  output logic                     drop_o,
  output logic [FNUM_W-1:0]        drop_fnum_o
`ifdef ARTEC_FRAME_SYNC_STAT_EN
  ,
  output logic [31:0]              drop_cnt_o,
  output logic [31:0]              sync_cnt_o,
  output logic [CH_NUM-1:0]        drop_mask_o
`endif
);

  sync_state_e       state;
  logic [FNUM_W-1:0] last_fnum;
  logic [FNUM_W-1:0] sel_fnum;
  logic              sel_found;
  logic              fire;
  logic [FB_NUM-1:0] col_complete;
  logic [FB_NUM-1:0] col_expire;
  logic [FB_NUM-1:0] col_clear;
`ifdef ARTEC_FRAME_SYNC_STAT_EN
  logic [CH_NUM-1:0] col_missing [FB_NUM];
`endif

  for (genvar f = 0; f < FB_NUM; f++) begin : g_col
    artec_frame_sync_col #(
      .CH_NUM  (CH_NUM),
      .FNUM_W  (FNUM_W),
      .TO_W    (TO_W),
      .COL_IDX (f)
    ) u_col (
      .clk         (clk),
      .rstn        (rstn),
      .ch_enable_i (ch_enable_i),
      .eof_valid_i (eof_valid_i),
      .eof_fnum_i  (eof_fnum_i),
      .timeout_i   (timeout_i),
      .clear_i     (col_clear[f]),
      .complete_o  (col_complete[f]),
      .expire_o    (col_expire[f])
`ifdef ARTEC_FRAME_SYNC_STAT_EN
      ,
      .missing_o   (col_missing[f])
`endif
    );
  end

  // Circular priority select starting just after the last emitted frame.
  always_comb begin
    logic [FNUM_W-1:0] idx;
    sel_found = 1'b0;
    sel_fnum  = '0;
    idx       = '0;
    for (int i = 0; i < FB_NUM; i++) begin
      idx = last_fnum + FNUM_W'(i + 1);
      if (!sel_found && col_complete[idx]) begin
        sel_found = 1'b1;
        sel_fnum  = idx;
      end
    end
  end

  // Expiry arbitration: lowest expiring column wins this cycle.
  always_comb begin
    drop_o      = 1'b0;
    drop_fnum_o = '0;
    for (int f = FB_NUM - 1; f >= 0; f--) begin
      if (col_expire[f]) begin
        drop_o      = 1'b1;
        drop_fnum_o = FNUM_W'(f);
      end
    end
  end

  assign fire = sel_found && ((state == IDLE) || sync_ready_i);

  // Clear the column being emitted and the column being dropped.
  always_comb begin
    col_clear = '0;
    for (int f = 0; f < FB_NUM; f++) begin
      col_clear[f] = (fire && (sel_fnum == FNUM_W'(f))) ||
                     (drop_o && (drop_fnum_o == FNUM_W'(f)));
    end
  end

  // Output FSM: latch a frame when idle or when the held one is accepted.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      sync_valid_o <= 1'b0;
      sync_fnum_o  <= '0;
      last_fnum    <= '1;
    end else if (fire) begin
      state        <= HOLD;
      sync_valid_o <= 1'b1;
      sync_fnum_o  <= sel_fnum;
      last_fnum    <= sel_fnum;
    end else if ((state == HOLD) && sync_ready_i) begin
      state        <= IDLE;
      sync_valid_o <= 1'b0;
    end
  end

`ifdef ARTEC_FRAME_SYNC_STAT_EN
  // Statistics: handshake count wraps, drop count saturates, mask follows last drop.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      drop_cnt_o  <= '0;
      sync_cnt_o  <= '0;
      drop_mask_o <= '0;
    end else begin
      if (sync_valid_o && sync_ready_i) begin
        sync_cnt_o <= sync_cnt_o + 32'd1;
      end
      if (drop_o) begin
        if (drop_cnt_o != '1) begin
          drop_cnt_o <= drop_cnt_o + 32'd1;
        end
        drop_mask_o <= col_missing[drop_fnum_o];
      end
    end
  end
`endif

endmodule

// File: tb/tb_artec_frame_sync_tracker.sv
// Directed self-checking bench for artec_frame_sync_tracker (3 channels, 8 buffers).
module tb_artec_frame_sync_tracker;
  import artec_dma_pkg::*;

  localparam int CH = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic [CH-1:0] ch_enable;
  logic [15:0] timeout;
  logic [CH-1:0] eof_valid;
  logic [CH*3-1:0] eof_fnum;
  logic        sync_valid;
  logic        sync_ready;
  logic [2:0]  sync_fnum;
  logic        drop;
  logic [2:0]  drop_fnum;
`ifdef ARTEC_FRAME_SYNC_STAT_EN
  logic [31:0] drop_cnt;
  logic [31:0] sync_cnt;
  logic [CH-1:0] drop_mask;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  artec_frame_sync_tracker #(
    .CH_NUM (CH),
    .FB_NUM (8),
    .TO_W   (16)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .ch_enable_i  (ch_enable),
    .timeout_i    (timeout),
    .eof_valid_i  (eof_valid),
    .eof_fnum_i   (eof_fnum),
    .sync_valid_o (sync_valid),
    .sync_ready_i (sync_ready),
    .sync_fnum_o  (sync_fnum),
    .drop_o       (drop),
    .drop_fnum_o  (drop_fnum)
`ifdef ARTEC_FRAME_SYNC_STAT_EN
    ,
    .drop_cnt_o   (drop_cnt),
    .sync_cnt_o   (sync_cnt),
    .drop_mask_o  (drop_mask)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle of EOF strobes; channel i reports frame fi.
  task automatic send(input logic [CH-1:0] v, input fnum_t f0, input fnum_t f1, input fnum_t f2);
    eof_valid = v;
    eof_fnum  = {f2, f1, f0};
    tick();
    eof_valid = '0;
  endtask

  initial begin
    rstn       = 1'b0;
    ch_enable  = 3'b111;
    timeout    = 16'd0;
    eof_valid  = '0;
    eof_fnum   = '0;
    sync_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(sync_valid), 32'd0);
    check("rst_fnum", 32'(sync_fnum), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_drop_fnum", 32'(drop_fnum), 32'd0);
    rstn = 1'b1;
    tick();

    // Staggered EOFs for frame 2; valid two edges after the last one.
    send(3'b001, 3'd2, 3'd0, 3'd0);
    send(3'b010, 3'd0, 3'd2, 3'd0);
    check("t1_partial", 32'(sync_valid), 32'd0);
    send(3'b100, 3'd0, 3'd0, 3'd2);
    check("t1_latency", 32'(sync_valid), 32'd0);
    tick();
    check("t1_valid", 32'(sync_valid), 32'd1);
    check("t1_fnum", 32'(sync_fnum), 32'd2);
    sync_ready = 1'b1;
    tick();
    check("t1_accept", 32'(sync_valid), 32'd0);
    sync_ready = 1'b0;
    tick();
    check("t1_no_resync", 32'(sync_valid), 32'd0);

    // Emit frame 3 so the next search starts at 4.
    send(3'b111, 3'd3, 3'd3, 3'd3);
    tick();
    check("t2_f3", 32'(sync_fnum), 32'd3);
    sync_ready = 1'b1;
    tick();
    sync_ready = 1'b0;
    check("t2_f3_acc", 32'(sync_valid), 32'd0);
    // Columns 1 and 5 complete together: 5 first.
    send(3'b111, 3'd1, 3'd1, 3'd5);
    send(3'b111, 3'd5, 3'd5, 3'd1);
    tick();
    check("t2_first_valid", 32'(sync_valid), 32'd1);
    check("t2_first_fnum", 32'(sync_fnum), 32'd5);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t2_hold_valid", 32'(sync_valid), 32'd1);
      check("t2_hold_fnum", 32'(sync_fnum), 32'd5);
    end
    sync_ready = 1'b1;
    tick();
    check("t2_second_valid", 32'(sync_valid), 32'd1);
    check("t2_second_fnum", 32'(sync_fnum), 32'd1);
    tick();
    check("t2_drain", 32'(sync_valid), 32'd0);
    sync_ready = 1'b0;

    // Channel 1 disabled: frame 4 syncs on ch0+ch2.
    ch_enable = 3'b101;
    send(3'b101, 3'd4, 3'd0, 3'd4);
    tick();
    check("t3_dis_valid", 32'(sync_valid), 32'd1);
    check("t3_dis_fnum", 32'(sync_fnum), 32'd4);
    sync_ready = 1'b1;
    tick();
    sync_ready = 1'b0;
    ch_enable = 3'b111;
    send(3'b101, 3'd6, 3'd0, 3'd6);
    tick();
    tick();
    check("t3_wait_ch1", 32'(sync_valid), 32'd0);
    send(3'b010, 3'd0, 3'd6, 3'd0);
    check("t3_ch1_lat", 32'(sync_valid), 32'd0);
    tick();
    check("t3_reen_valid", 32'(sync_valid), 32'd1);
    check("t3_reen_fnum", 32'(sync_fnum), 32'd6);
    sync_ready = 1'b1;
    tick();
    sync_ready = 1'b0;
    check("t3_accept", 32'(sync_valid), 32'd0);

    // Expiry: only ch0 reports frame 7, timeout 20.
    timeout = 16'd20;
    send(3'b001, 3'd7, 3'd0, 3'd0);
    for (int j = 1; j < 20; j++) begin
      tick();
      check("t4_no_drop_early", 32'(drop), 32'd0);
    end
    tick();
    check("t4_drop", 32'(drop), 32'd1);
    check("t4_drop_fnum", 32'(drop_fnum), 32'd7);
    tick();
    check("t4_drop_single", 32'(drop), 32'd0);
    check("t4_no_sync", 32'(sync_valid), 32'd0);
`ifdef ARTEC_FRAME_SYNC_STAT_EN
    check("t4_drop_mask", 32'(drop_mask), 32'b110);
    check("t4_drop_cnt", drop_cnt, 32'd1);
`endif
    timeout = 16'd0;

    // Frames 0..7 complete on consecutive cycles with ready high.
    sync_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      send(3'b111, fnum_t'(f), fnum_t'(f), fnum_t'(f));
      if (f > 0) begin
        check("t5_stream_valid", 32'(sync_valid), 32'd1);
        check("t5_stream_fnum", 32'(sync_fnum), 32'(f - 1));
      end
    end
    tick();
    check("t5_last_valid", 32'(sync_valid), 32'd1);
    check("t5_last_fnum", 32'(sync_fnum), 32'd7);
    tick();
    check("t5_drain", 32'(sync_valid), 32'd0);
    sync_ready = 1'b0;

    // No channel enabled: nothing ever completes.
    ch_enable = 3'b000;
    send(3'b111, 3'd0, 3'd0, 3'd0);
    tick();
    check("t6_none_enabled", 32'(sync_valid), 32'd0);
    ch_enable = 3'b111;
    tick();
    check("t6_reenable_clean", 32'(sync_valid), 32'd0);

    // Reset during HOLD on frame 3, then resync.
    send(3'b111, 3'd3, 3'd3, 3'd3);
    tick();
    check("t7_hold_fnum", 32'(sync_fnum), 32'd3);
    rstn = 1'b0;
    tick();
    check("t7_rst_valid", 32'(sync_valid), 32'd0);
    check("t7_rst_fnum", 32'(sync_fnum), 32'd0);
    check("t7_rst_drop", 32'(drop), 32'd0);
    rstn = 1'b1;
    tick();
    check("t7_post_rst_idle", 32'(sync_valid), 32'd0);
    send(3'b111, 3'd3, 3'd3, 3'd3);
    tick();
    check("t7_resync_valid", 32'(sync_valid), 32'd1);
    check("t7_resync_fnum", 32'(sync_fnum), 32'd3);
    sync_ready = 1'b1;
    tick();
    sync_ready = 1'b0;
    check("t7_accept", 32'(sync_valid), 32'd0);
`ifdef ARTEC_FRAME_SYNC_STAT_EN
    check("t7_sync_cnt", sync_cnt, 32'd1);
    check("t7_drop_cnt", drop_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
